// File: rtl/store_pkg.sv
// -----------------------------------------------------------------------------
// store_pkg
// Shared types and encodings for the store unit:
//   state_t  - store FSM states
//   F3_*     - funct3 store size encodings (sb/sh/sw/sd)
//   cause_t  - fault cause codes reported on fault_cause
// -----------------------------------------------------------------------------
package store_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_BEAT0,
      ST_BEAT1,
      ST_DONE,
      ST_FAULT
   } state_t;

   localparam logic [2:0] F3_SB = 3'b000;
   localparam logic [2:0] F3_SH = 3'b001;
   localparam logic [2:0] F3_SW = 3'b010;
   localparam logic [2:0] F3_SD = 3'b011;

   typedef enum logic [1:0] {
      CAUSE_NONE     = 2'b00,
      CAUSE_MISALIGN = 2'b01,
      CAUSE_ILLEGAL  = 2'b10,
      CAUSE_TIMEOUT  = 2'b11
   } cause_t;

endpackage : store_pkg

// File: rtl/store_lane_align.sv
// -----------------------------------------------------------------------------
// store_lane_align
// Combinational lane steering for a store. The store's bytes are placed on a
// double-width (two-word) bus at the byte offset; the low word is beat 0 and
// the high word is beat 1. Lanes not covered by the store are zero.
//
// Ports:
//   offset            in  byte offset of the address within a word
//   size_log2         in  log2 of the store size in bytes (funct3[1:0])
//   data              in  LSB-justified store data
//   be0 / wdata0      out byte enables / data for the first beat
//   be1 / wdata1      out byte enables / data for the second beat
//   needs_second_beat out store spills into the next word
// -----------------------------------------------------------------------------
module store_lane_align #(
   parameter  int XLEN  = 32,
   localparam int BYTES = XLEN / 8,
   localparam int OFF_W = $clog2(BYTES)
) (
   input  logic [OFF_W-1:0] offset,
   input  logic [1:0]       size_log2,
   input  logic [XLEN-1:0]  data,
   output logic [BYTES-1:0] be0,
   output logic [XLEN-1:0]  wdata0,
   output logic [BYTES-1:0] be1,
   output logic [XLEN-1:0]  wdata1,
   output logic             needs_second_beat
);

   logic [BYTES-1:0]   size_mask;
   logic [XLEN-1:0]    data_mask;
   logic [2*BYTES-1:0] be_wide;
   logic [2*XLEN-1:0]  data_wide;
   int                 n_bytes;

   always_comb begin
      // NOTE: every variable gets a default before any conditional logic so
      // no path leaves a value held, which would infer a latch.
      size_mask = '0;
      data_mask = '0;
      n_bytes   = 1 << size_log2;
      for (int i = 0; i < BYTES; i++) begin
         if (i < n_bytes) begin
            size_mask[i]        = 1'b1;
            data_mask[8*i +: 8] = 8'hFF;
         end
      end
      be_wide   = {{BYTES{1'b0}}, size_mask} << offset;
      data_wide = {{XLEN{1'b0}}, data & data_mask} << {offset, 3'b000};
   end

   assign be0               = be_wide[BYTES-1:0];
   assign be1               = be_wide[2*BYTES-1:BYTES];
   assign wdata0            = data_wide[XLEN-1:0];
   assign wdata1            = data_wide[2*XLEN-1:XLEN];
   assign needs_second_beat = |be1;

endmodule : store_lane_align

// File: rtl/store_unit.sv
// -----------------------------------------------------------------------------
// store_unit
// Multicycle store engine between the core and data memory. Accepts one
// request at a time, drives a held write beat with lane-aligned data and byte
// enables, waits for mem_ack with an optional per-beat timeout, and reports
// misaligned / illegal-size / timeout faults.
//
// Build option: define STORE_MISALIGNED_SPLIT_EN to issue misaligned stores
// (split into two beats when they cross a word) instead of faulting them.
//
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   req_valid/req_ready        request handshake (ready only in IDLE)
//   req_addr/req_data/funct3   byte address, LSB-justified data, size code
//   mem_we/addr/wdata/be       registered write beat, held until mem_ack
//   mem_ack                    memory accepted the current beat
//   done                       one-cycle pulse on successful completion
//   fault/fault_cause          one-cycle pulse on abort, with its cause
// -----------------------------------------------------------------------------
module store_unit
   import store_pkg::*;
#(
   parameter int XLEN           = 32,
   parameter int ADDR_W         = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [ADDR_W-1:0]    req_addr,
   input  logic [XLEN-1:0]      req_data,
   input  logic [2:0]           req_funct3,
   output logic                 mem_we,
   output logic [ADDR_W-1:0]    mem_addr,
   output logic [XLEN-1:0]      mem_wdata,
   output logic [XLEN/8-1:0]    mem_be,
   input  logic                 mem_ack,
   output logic                 done,
   output logic                 fault,
   output logic [1:0]           fault_cause
);

   localparam int BYTES = XLEN / 8;
   localparam int OFF_W = $clog2(BYTES);
   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   // Largest legal size code for this data width (sw on RV32, sd on RV64).
   localparam logic [1:0] SIZE_LOG2_MAX = (XLEN == 64) ? F3_SD[1:0] : F3_SW[1:0];

   state_t           state, state_nxt;
   cause_t           cause_q, cause_nxt;
   logic [CNT_W-1:0] cnt_q, cnt_nxt;

   logic [OFF_W-1:0] offset;
   logic [BYTES-1:0] be0, be1;
   logic [XLEN-1:0]  wd0, wd1;
   logic             needs_second;
   logic             accept, illegal, misaligned_fault, second_q, timeout_hit;
   logic             load_beat0, load_beat1, clear_beat;

   assign offset = req_addr[OFF_W-1:0];

   store_lane_align #(.XLEN(XLEN)) u_align (
      .offset            (offset),
      .size_log2         (req_funct3[1:0]),
      .data              (req_data),
      .be0               (be0),
      .wdata0            (wd0),
      .be1               (be1),
      .wdata1            (wd1),
      .needs_second_beat (needs_second)
   );

   assign req_ready   = (state == ST_IDLE);
   assign accept      = req_valid && req_ready;
   assign illegal     = req_funct3[2] || (req_funct3[1:0] > SIZE_LOG2_MAX);
   // Counter holds the number of un-acked cycles already spent in this beat,
   // so the last allowed cycle is the one where it equals TIMEOUT_CYCLES-1.
   assign timeout_hit = (TIMEOUT_CYCLES != 0) &&
                        (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

`ifdef STORE_MISALIGNED_SPLIT_EN
   logic [BYTES-1:0] be1_q;
   logic [XLEN-1:0]  wd1_q;
   logic             second_r;

   assign misaligned_fault = 1'b0;
   assign second_q         = second_r;
`else
   logic unused_beat1;

   // Offset must be a multiple of the access size.
   assign misaligned_fault = |(offset & OFF_W'((4'd1 << req_funct3[1:0]) - 4'd1));
   assign second_q         = 1'b0;
   assign unused_beat1     = ^{be1, wd1, needs_second, load_beat1};
`endif

   // ---------------------------------------------------------------- next state
   always_comb begin
      state_nxt  = state;
      cause_nxt  = cause_q;
      cnt_nxt    = cnt_q;
      load_beat0 = 1'b0;
      load_beat1 = 1'b0;
      clear_beat = 1'b0;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               cnt_nxt = '0;
               if (illegal) begin
                  state_nxt = ST_FAULT;
                  cause_nxt = CAUSE_ILLEGAL;
               end else if (misaligned_fault) begin
                  state_nxt = ST_FAULT;
                  cause_nxt = CAUSE_MISALIGN;
               end else begin
                  state_nxt  = ST_BEAT0;
                  load_beat0 = 1'b1;
               end
            end
         end
         ST_BEAT0, ST_BEAT1: begin
            // Ack is checked before the limit so a late ack still completes.
            if (mem_ack) begin
               cnt_nxt = '0;
               if ((state == ST_BEAT0) && second_q) begin
                  state_nxt  = ST_BEAT1;
                  load_beat1 = 1'b1;
               end else begin
                  state_nxt  = ST_DONE;
                  clear_beat = 1'b1;
               end
            end else if (timeout_hit) begin
               state_nxt  = ST_FAULT;
               cause_nxt  = CAUSE_TIMEOUT;
               clear_beat = 1'b1;
            end else begin
               cnt_nxt = cnt_q + CNT_W'(1);
            end
         end
         ST_DONE, ST_FAULT: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------ state register
   always_ff @(posedge clk or negedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (!reset) begin
         state   <= ST_IDLE;
         cause_q <= CAUSE_NONE;
         cnt_q   <= '0;
      end else begin
         state   <= state_nxt;
         cause_q <= cause_nxt;
         cnt_q   <= cnt_nxt;
      end
   end

   // ---------------------------------------------------- beat output registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_be    <= '0;
`ifdef STORE_MISALIGNED_SPLIT_EN
         second_r  <= 1'b0;
         be1_q     <= '0;
         wd1_q     <= '0;
`endif
      end else if (load_beat0) begin
         mem_addr  <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
         mem_wdata <= wd0;
         mem_be    <= be0;
`ifdef STORE_MISALIGNED_SPLIT_EN
         second_r  <= needs_second;
         be1_q     <= be1;
         wd1_q     <= wd1;
      end else if (load_beat1) begin
         mem_addr  <= mem_addr + ADDR_W'(BYTES);
         mem_wdata <= wd1_q;
         mem_be    <= be1_q;
         second_r  <= 1'b0;
`endif
      end else if (clear_beat) begin
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_be    <= '0;
      end
   end

   assign mem_we      = (state == ST_BEAT0) || (state == ST_BEAT1);
   assign done        = (state == ST_DONE);
   assign fault       = (state == ST_FAULT);
   assign fault_cause = fault ? cause_q : CAUSE_NONE;

endmodule : store_unit

// File: tb/tb_store_unit.sv
// -----------------------------------------------------------------------------
// tb_store_unit
// Drives a 32-bit and a 64-bit store_unit (both TIMEOUT_CYCLES=4) with directed
// and random stores. Expected beats come from a byte-by-byte reference model:
// each store byte k lands at address addr+k, i.e. word (addr+k)/BYTES, lane
// (addr+k)%BYTES.
// -----------------------------------------------------------------------------
module tb_store_unit;

   localparam int TMO = 4;
`ifdef STORE_MISALIGNED_SPLIT_EN
   localparam bit SPLIT = 1'b1;
`else
   localparam bit SPLIT = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        v32, v64, ack, sel64;
   logic [31:0] req_addr;
   logic [63:0] req_data;
   logic [2:0]  req_funct3;

   logic        r32, we32, done32, fault32;
   logic [31:0] a32, wd32;
   logic [3:0]  be32;
   logic [1:0]  fc32;
   logic        r64, we64, done64, fault64;
   logic [31:0] a64;
   logic [63:0] wd64;
   logic [7:0]  be64;
   logic [1:0]  fc64;

   // selected-DUT observation
   logic        o_ready, o_we, o_done, o_fault;
   logic [31:0] o_addr;
   logic [63:0] o_wd;
   logic [7:0]  o_be;
   logic [1:0]  o_fc;

   int n_vec = 0;
   int n_err = 0;

   // reference model results
   int          exp_nb;
   logic [1:0]  exp_cause;
   logic [31:0] exp_addr [2];
   logic [7:0]  exp_be   [2];
   logic [63:0] exp_wd   [2];

   always #5 clk = ~clk;

   store_unit #(.XLEN(32), .ADDR_W(32), .TIMEOUT_CYCLES(TMO)) u_dut32 (
      .clk(clk), .reset(reset),
      .req_valid(v32), .req_ready(r32), .req_addr(req_addr),
      .req_data(req_data[31:0]), .req_funct3(req_funct3),
      .mem_we(we32), .mem_addr(a32), .mem_wdata(wd32), .mem_be(be32),
      .mem_ack(ack), .done(done32), .fault(fault32), .fault_cause(fc32)
   );

   store_unit #(.XLEN(64), .ADDR_W(32), .TIMEOUT_CYCLES(TMO)) u_dut64 (
      .clk(clk), .reset(reset),
      .req_valid(v64), .req_ready(r64), .req_addr(req_addr),
      .req_data(req_data), .req_funct3(req_funct3),
      .mem_we(we64), .mem_addr(a64), .mem_wdata(wd64), .mem_be(be64),
      .mem_ack(ack), .done(done64), .fault(fault64), .fault_cause(fc64)
   );

   always_comb begin
      if (sel64) begin
         o_ready = r64;  o_we = we64;  o_done = done64;  o_fault = fault64;
         o_addr  = a64;  o_wd = wd64;  o_be   = be64;    o_fc    = fc64;
      end else begin
         o_ready = r32;  o_we = we32;  o_done = done32;  o_fault = fault32;
         o_addr  = a32;  o_wd = {32'd0, wd32};  o_be = {4'd0, be32};  o_fc = fc32;
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model(input bit is64, input logic [31:0] addr,
                        input logic [63:0] data, input logic [2:0] f3);
      int nbytes, size, b, lane;
      logic [31:0] a, w, w0;
      nbytes    = is64 ? 8 : 4;
      size      = 1 << f3[1:0];
      exp_nb    = 0;
      exp_cause = 2'b00;
      for (int i = 0; i < 2; i++) begin
         exp_addr[i] = '0; exp_be[i] = '0; exp_wd[i] = '0;
      end
      if (f3[2] || size > nbytes) begin
         exp_cause = 2'b10;
      end else if ((addr % size) != 0 && !SPLIT) begin
         exp_cause = 2'b01;
      end else begin
         w0 = addr / nbytes;
         for (int k = 0; k < size; k++) begin
            a    = addr + k;
            w    = a / nbytes;
            b    = int'(w - w0);
            lane = int'(a % nbytes);
            exp_addr[b]              = w * nbytes;
            exp_be[b][lane]          = 1'b1;
            exp_wd[b][8*lane +: 8]   = data[8*k +: 8];
            if (b + 1 > exp_nb) exp_nb = b + 1;
         end
      end
   endtask

   // d0/d1: un-acked cycles before ack in beat 0/1 (>= TMO means timeout)
   task automatic run_store(input bit is64, input logic [31:0] addr,
                            input logic [63:0] data, input logic [2:0] f3,
                            input int d0, input int d1);
      int  guard, d;
      bit  timed_out;
      model(is64, addr, data, f3);
      sel64 = is64;
      @(negedge clk);
      guard = 0;
      while (!o_ready && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      check("idle_ready", o_ready, 1);
      req_addr = addr; req_data = data; req_funct3 = f3;
      v32 = !is64; v64 = is64;
      @(negedge clk);
      v32 = 1'b0; v64 = 1'b0;
      if (exp_nb == 0) begin
         check("req_fault", o_fault, 1);
         check("req_cause", o_fc, exp_cause);
         check("req_fault_no_we", o_we, 0);
         check("req_fault_no_done", o_done, 0);
         @(negedge clk);
         check("post_fault_ready", o_ready, 1);
         check("post_fault_pulse", o_fault, 0);
         return;
      end
      timed_out = 1'b0;
      for (int b = 0; b < exp_nb && !timed_out; b++) begin
         d = (b == 0) ? d0 : d1;
         for (int w = 0; w < 64; w++) begin
            check("beat_we", o_we, 1);
            check("beat_not_ready", o_ready, 0);
            check("beat_addr", o_addr, exp_addr[b]);
            check("beat_be", o_be, exp_be[b]);
            check("beat_wdata", o_wd, exp_wd[b]);
            if (w == d) begin
               ack = 1'b1;
               @(negedge clk);
               ack = 1'b0;
               break;
            end else if (w == TMO - 1) begin
               timed_out = 1'b1;
               @(negedge clk);
               break;
            end else begin
               @(negedge clk);
            end
         end
      end
      if (timed_out) begin
         check("tmo_fault", o_fault, 1);
         check("tmo_cause", o_fc, 2'b11);
         check("tmo_we_low", o_we, 0);
         check("tmo_no_done", o_done, 0);
      end else begin
         check("done_pulse", o_done, 1);
         check("done_no_fault", o_fault, 0);
         check("done_we_low", o_we, 0);
         check("done_cause_zero", o_fc, 0);
      end
      @(negedge clk);
      check("end_ready", o_ready, 1);
      check("end_done_low", o_done, 0);
      check("end_fault_low", o_fault, 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ready"}, o_ready, 1);
      check({tag, "_we"},    o_we, 0);
      check({tag, "_addr"},  o_addr, 0);
      check({tag, "_be"},    o_be, 0);
      check({tag, "_wdata"}, o_wd, 0);
      check({tag, "_done"},  o_done, 0);
      check({tag, "_fault"}, o_fault, 0);
      check({tag, "_cause"}, o_fc, 0);
   endtask

   initial begin
      reset = 1'b0; v32 = 1'b0; v64 = 1'b0; ack = 1'b0; sel64 = 1'b0;
      req_addr = '0; req_data = '0; req_funct3 = '0;
      #1;
      check_reset_outputs("rst32");
      sel64 = 1'b1; #1;
      check_reset_outputs("rst64");
      @(negedge clk);
      reset = 1'b1;

      // directed cases
      run_store(0, 32'h0, 64'h8, 3'b010, 0, 0);              // sw, immediate ack
      run_store(0, 32'h7, 64'hAABBCCDD, 3'b000, 0, 0);       // sb lane 3
      run_store(0, 32'h3, 64'h1234, 3'b001, 0, 0);           // sh crossing word
      run_store(0, 32'h0, 64'h1, 3'b011, 0, 0);              // sd on RV32: illegal
      run_store(0, 32'h0, 64'h1, 3'b110, 0, 0);              // funct3[2]: illegal
      run_store(1, 32'h8, 64'h0123456789ABCDEF, 3'b011, 0, 0); // sd on RV64
      run_store(0, 32'h10, 64'h55, 3'b010, 1000, 0);         // ack never: timeout
      run_store(0, 32'h14, 64'h66, 3'b010, TMO - 1, 0);      // ack in last cycle
      run_store(1, 32'h6, 64'hBEEF, 3'b001, 2, 0);           // sh lanes 6..7

      // reset in the middle of a beat
      sel64 = 1'b0;
      @(negedge clk);
      req_addr = 32'h20; req_data = 64'h77; req_funct3 = 3'b010; v32 = 1'b1;
      @(negedge clk);
      v32 = 1'b0;
      check("pre_rst_we", o_we, 1);
      @(negedge clk);
      check("pre_rst_we2", o_we, 1);
      #2 reset = 1'b0;
      #1 check_reset_outputs("midbeat");
      @(negedge clk);
      reset = 1'b1;
      run_store(0, 32'h24, 64'hCAFEF00D, 3'b010, 0, 0);

      // random traffic
      for (int i = 0; i < 150; i++) begin
         bit          is64;
         logic [2:0]  f3;
         logic [31:0] addr;
         int          d0, d1, sz;
         is64 = (i % 3 == 0);
         f3   = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 3))
                                           : 3'($urandom_range(4, 7));
         addr = $urandom & 32'h0FFF_FFFF;
         sz   = 1 << f3[1:0];
         if ($urandom_range(0, 1) == 1) addr = addr & ~(32'(sz) - 32'd1);
         d0   = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 2) : $urandom_range(3, 6);
         d1   = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 2) : $urandom_range(3, 6);
         run_store(is64, addr, {$urandom, $urandom}, f3, d0, d1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_store_unit

// File: doc/store_unit.md
# store_unit

Parametrised multicycle store engine for the RISC-V core, sitting between the control FSM/datapath and data memory. It accepts one store request at a time and turns it into a held memory write beat with lane-aligned data and byte enables. It supports byte, half, word and (when XLEN=64) double stores, waits on a memory acknowledge with a timeout, and reports misaligned, illegal-size and timeout faults.

## Interface
- XLEN, default 32: data width in bits (32 or 64); BYTES = XLEN/8.
- ADDR_W, default 32: address width.
- TIMEOUT_CYCLES, default 16: maximum cycles waiting on `mem_ack` per beat; 0 disables the timeout.

- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  store request present.
- req_ready  out  1  unit idle and able to accept a request.
- req_addr  in  ADDR_W  byte address (rs1 + imm).
- req_data  in  XLEN  rs2 value, LSB-justified.
- req_funct3  in  3  000 sb, 001 sh, 010 sw, 011 sd.
- mem_we  out  1  write beat active.
- mem_addr  out  ADDR_W  word-aligned beat address (low log2(BYTES) bits zero).
- mem_wdata  out  XLEN  lane-shifted write data.
- mem_be  out  BYTES  byte enables.
- mem_ack  in  1  memory accepted the current beat.
- done  out  1  one-cycle pulse when the store completes successfully.
- fault  out  1  one-cycle pulse when a store aborts.
- fault_cause  out  2  01 misaligned, 10 illegal size, 11 timeout; valid while `fault` is high, 00 otherwise.

## Operation
- States: IDLE, BEAT0, BEAT1, DONE, FAULT.
- IDLE: `req_ready`=1. A request is accepted on a rising edge when `req_valid`&&`req_ready`. Address, data and size are registered at acceptance.
- Size = 1 << funct3[1:0].
  - funct3[2]=1 is illegal.
  - Size > BYTES is illegal.
  - An illegal request goes to FAULT with cause 10 and never asserts `mem_we`.
- Offset = addr[log2(BYTES)-1:0]. A request is misaligned when offset is not a multiple of size.
  - Without the macro, a misaligned request goes to FAULT with cause 01 and never asserts `mem_we`.
- Aligned request: go to BEAT0.
  - `mem_be` = ((1<<size)-1) << offset.
  - `mem_wdata` = req_data << (8*offset).
  - Unused lanes are zero.
- BEAT0/BEAT1: `mem_we`=1 and all `mem_*` outputs are held stable until `mem_ack` is sampled high.
  - On ack, go to BEAT1 if a second beat is pending, else DONE.
  - The wait counter clears on each beat entry and increments every beat cycle without ack.
  - When the counter reaches TIMEOUT_CYCLES (nonzero), drop `mem_we` and go to FAULT with cause 11.
  - An ack arriving in the same cycle the limit is reached wins: the beat completes.
- DONE: `done`=1 for one cycle, then IDLE.
- FAULT: `fault`=1 and `fault_cause` valid for one cycle, then IDLE. No partial retry.
- Reset (asynchronous, any state): state goes to IDLE. All outputs reset: `req_ready`=1, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `mem_be`=0, `done`=0, `fault`=0, `fault_cause`=00. An in-flight beat is abandoned.

## Timing
- Minimum latency, acceptance to `done`:
  - accept at edge N;
  - `mem_we` high during cycle N+1 with ack in the same cycle;
  - `done` high in cycle N+2;
  - `req_ready` high again in cycle N+3.
- A two-beat store adds one cycle per extra beat plus any wait cycles.
- Fault on illegal or misaligned requests: `fault` is high in cycle N+1, and `mem_we` never rises.
- `mem_*` outputs are registered; they change only on beat entry or on leaving a beat.

## Configuration
- `STORE_MISALIGNED_SPLIT_EN` defined:
  - A misaligned request that stays within one word is issued as a single beat with shifted enables.
  - A request crossing a word boundary is split into two beats:
    - BEAT0 at the aligned address, upper lanes from offset up;
    - BEAT1 at aligned address + BYTES, remaining low lanes carrying the high bytes of `req_data`.
  - Cause 01 is never raised.
- Undefined: every misaligned request faults with cause 01, and the BEAT1 path is not built.

## Structure
- Package `store_pkg`:
  - state enum;
  - funct3 size encodings (SB/SH/SW/SD);
  - fault cause codes (CAUSE_NONE, CAUSE_MISALIGN, CAUSE_ILLEGAL, CAUSE_TIMEOUT).
- Sub-module `store_lane_align` (combinational, parametrised by XLEN): from offset, size and data it produces per-beat `be`/`wdata` and a `needs_second_beat` flag. The FSM, wait counter and registers stay in `store_unit`.

## Test plan
- XLEN=32; sw of 0x00000008 to addr 0x0, ack immediate -> `mem_addr`=0x0, `mem_be`=1111, `mem_wdata`=0x00000008; `done` 2 cycles after acceptance.
- sb of 0xAABBCCDD to addr 0x7 -> `mem_addr`=0x4, `mem_be`=1000, `mem_wdata`=0xDD000000.
- sh of 0x1234 to addr 0x3:
  - macro off -> `fault`, cause 01, `mem_we` never high;
  - macro on -> beat0 addr 0x0, be 1000, wdata 0x34000000; beat1 addr 0x4, be 0001, wdata 0x00000012; single `done`.
- funct3=011 with XLEN=32 -> `fault`, cause 10, no write. XLEN=64 sd to addr 0x8 -> be 0xFF, single beat.
- TIMEOUT_CYCLES=4 with `mem_ack` held low -> `mem_we` high exactly 4 cycles, then `fault` cause 11; ack arriving in the 4th cycle -> `done`, not `fault`.
- Reset driven low mid-BEAT0 -> `mem_we`=0 immediately; after release `req_ready`=1; a following sw completes normally.
